// File: rtl/out_bram_writer.sv
// Rescales systolic-array result beats into WIDTH-bit elements and packs CHUNK_SIZE of them per output-BRAM word.
// Optional clamping instead of wrapping is enabled by defining OUT_SAT_EN.
module out_bram_writer #(
    parameter int WIDTH             = 16,
    parameter int FRAC_WIDTH        = 8,
    parameter int ACC_WIDTH         = 32,
    parameter int BLOCK_SIZE        = 2,
    parameter int CHUNK_SIZE        = 4,
    parameter int W_OUTER_DIMENSION = 64,
    parameter int I_OUTER_DIMENSION = 2754,
    parameter int ADDR_WIDTH        = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ACC_WIDTH*BLOCK_SIZE-1:0]   in_data,
    output logic                              bram_en,
    output logic [WIDTH*CHUNK_SIZE/8-1:0]     bram_we,
    output logic [ADDR_WIDTH-1:0]             bram_addr,
    output logic [WIDTH*CHUNK_SIZE-1:0]       bram_din
);

    localparam int BEATS       = CHUNK_SIZE / BLOCK_SIZE;
    localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TOTAL_WORDS = (W_OUTER_DIMENSION / CHUNK_SIZE) * I_OUTER_DIMENSION;
    localparam int WORD_W      = WIDTH * CHUNK_SIZE;
    localparam int BE_W        = WORD_W / 8;
    localparam int LANE_W      = WIDTH * BLOCK_SIZE;

`ifdef OUT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [BEAT_W-1:0]       r_beat_cnt;
    logic [ADDR_WIDTH-1:0]   r_word_cnt;
    logic [WORD_W-1:0]       r_pack;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_in_ready;
    logic                    r_bram_en;
    logic [BE_W-1:0]         r_bram_we;
    logic [ADDR_WIDTH-1:0]   r_bram_addr;
    logic [WORD_W-1:0]       r_bram_din;

    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_last_word;
    logic [LANE_W-1:0]       w_lanes;
    logic [WORD_W-1:0]       w_pack_next;

    // Arithmetic shift floors toward minus infinity; the narrowing step either clamps or wraps.
    function automatic logic [WIDTH-1:0] rescale(input logic [ACC_WIDTH-1:0] acc);
`ifdef OUT_SAT_EN
        if (($signed(acc) >>> FRAC_WIDTH) > SAT_MAX)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (($signed(acc) >>> FRAC_WIDTH) < SAT_MIN)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return WIDTH'($signed(acc) >>> FRAC_WIDTH);
`else
        return WIDTH'($signed(acc) >>> FRAC_WIDTH);
`endif
    endfunction

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
        assign w_lanes[g*WIDTH +: WIDTH] = rescale(in_data[g*ACC_WIDTH +: ACC_WIDTH]);
    end

    assign w_accept    = in_valid && r_in_ready;
    assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));
    assign w_last_word = (r_word_cnt == ADDR_WIDTH'(TOTAL_WORDS - 1));

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_beat_cnt*LANE_W +: LANE_W] = w_lanes;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_word_cnt  <= '0;
            r_pack      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= '0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else if (clr) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_word_cnt  <= '0;
            r_pack      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= '0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_bram_en <= 1'b0;
            r_bram_we <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_beat_cnt <= '0;
                        r_word_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            r_bram_en   <= 1'b1;
                            r_bram_we   <= '1;
                            r_bram_addr <= r_word_cnt;
                            r_bram_din  <= w_pack_next;
                            r_beat_cnt  <= '0;
                            r_word_cnt  <= r_word_cnt + 1'b1;
                            if (w_last_word) begin
                                r_state    <= S_DONE;
                                r_done     <= 1'b1;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_pack     <= w_pack_next;
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign bram_en   = r_bram_en;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;

endmodule

// File: tb/tb_out_bram_writer.sv
// Bench for out_bram_writer with a 4-word, 2-beat-per-word geometry; expected writes queue up at stimulus time.
module tb_out_bram_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        bram_en;
    logic [7:0]  bram_we;
    logic [15:0] bram_addr;
    logic [63:0] bram_din;

    out_bram_writer #(
        .WIDTH(16), .FRAC_WIDTH(8), .ACC_WIDTH(32), .BLOCK_SIZE(2), .CHUNK_SIZE(4),
        .W_OUTER_DIMENSION(8), .I_OUTER_DIMENSION(2), .ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] din;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [63:0] m_pack;
    int          m_beat;
    int          m_word;

    logic [31:0] cur_in[16];
    logic [15:0] cur_exp[16];

    // Rescale vectors: element input and hand-derived output lane.
    localparam logic [31:0] RS_IN[16] = '{
        32'h0003_0000, 32'hFFFF_FF00, 32'h0100_0000, 32'hFF00_0000,
        32'hFFFF_FE80, 32'h007F_FF00, 32'hFF80_0000, 32'h7FFF_FF00,
        32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0180, 32'h8000_0000,
        32'h1234_5600, 32'h0000_7F00, 32'hFFFF_8000, 32'h0001_0000};
`ifdef OUT_SAT_EN
    localparam logic [15:0] RS_EXP[16] = '{
        16'h0300, 16'hFFFF, 16'h7FFF, 16'h8000,
        16'hFFFE, 16'h7FFF, 16'h8000, 16'h7FFF,
        16'h0000, 16'hFFFF, 16'h0001, 16'h8000,
        16'h7FFF, 16'h007F, 16'hFF80, 16'h0100};
`else
    localparam logic [15:0] RS_EXP[16] = '{
        16'h0300, 16'hFFFF, 16'h0000, 16'h0000,
        16'hFFFE, 16'h7FFF, 16'h8000, 16'hFFFF,
        16'h0000, 16'hFFFF, 16'h0001, 16'h0000,
        16'h3456, 16'h007F, 16'hFF80, 16'h0100};
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every BRAM write pops one expected word.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (bram_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr %0h din %0h", bram_addr, bram_din);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", bram_addr, e.addr);
                    check("wr_din", bram_din, e.din);
                    check("wr_we", bram_we, 8'hFF);
                    check("wr_done", done, e.last);
                end
            end else begin
                check("idle_we", {done, bram_we}, 9'h0);
            end
        end
    end

    task automatic start_pass();
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        m_beat   = 0;
        m_word   = 0;
        check("run_entry", {busy, in_ready}, 2'b11);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [31:0] lanes);
        int  n = 0;
        logic last;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("beat_timeout", 1'b0, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m_pack[m_beat*32 +: 32] = lanes;
        last = (m_beat == 1);
        if (last) begin
            sb.push_back('{16'(m_word), m_pack, (m_word == 3)});
            m_beat = 0;
            m_word++;
        end else begin
            m_beat++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("write_latency", bram_en, last);
    endtask

    task automatic run_pass(input bit gaps, input bit poke_start);
        start_pass();
        for (int b = 0; b < 8; b++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            if (poke_start && b == 3) start = 1'b1;
            send_beat({cur_in[2*b+1], cur_in[2*b]}, {cur_exp[2*b+1], cur_exp[2*b]});
            if (poke_start && b == 5) start = 1'b0;
        end
        check("done_with_last", {done, in_ready, busy}, 3'b101);
        @(negedge clk);
        check("busy_after_done", {busy, done, in_ready}, 3'b000);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0123_4567;
        m_pack   = '0;
        m_beat   = 0;
        m_word   = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, in_ready, bram_en, bram_we, bram_addr, bram_din}, 92'h0);
        rst_n = 1'b1;
        // in_valid held high while idle must be ignored.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outs", {busy, done, in_ready, bram_en, bram_we, bram_addr, bram_din}, 92'h0);
        end
        in_valid = 1'b0;

        for (int k = 0; k < 16; k++) begin
            cur_in[k]  = 32'(k) << 8;
            cur_exp[k] = 16'(k);
        end
        run_pass(1'b0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            cur_in[k]  = RS_IN[k];
            cur_exp[k] = RS_EXP[k];
        end
        run_pass(1'b0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            cur_in[k]  = 32'(k) << 8;
            cur_exp[k] = 16'(k);
        end
        run_pass(1'b1, 1'b1);

        start_pass();
        for (int b = 0; b < 3; b++)
            send_beat({cur_in[2*b+1], cur_in[2*b]}, {cur_exp[2*b+1], cur_exp[2*b]});
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("after_clr", {busy, done, in_ready, bram_en, bram_we, bram_addr, bram_din}, 92'h0);
        for (int k = 0; k < 16; k++) begin
            cur_in[k]  = (32'(k) << 8) + 32'h2000;
            cur_exp[k] = 16'(k) + 16'h0020;
        end
        run_pass(1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
